// File: rtl/frv_dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (LSU) has fixed priority. Port 1 gets a
// starvation guard. The grant stays locked across a stalled access.
module frv_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SW           = 8
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic [1:0]  req_cen,
  input  logic [1:0]  req_wen,
  input  logic [7:0]  req_strb,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_stall,
  output logic [1:0]  req_error,
  output logic [31:0] req_rdata,
  output logic        dmem_cen,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_stall,
  input  logic        dmem_error,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    grant;
  logic          done;

  // Grant is combinational so an IDLE request reaches memory in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant = 2'b00;
    if (!g_reset) begin
      case (state_q)
        IDLE: begin
          if (req_cen[1] && (!req_cen[0] || (starve_q >= LIMIT))) grant = 2'b10;
          else if (req_cen[0])                                    grant = 2'b01;
        end
        LOCK0:   grant = {1'b0, req_cen[0]};
        LOCK1:   grant = {req_cen[1], 1'b0};
        default: grant = 2'b00;
      endcase
    end
  end

  assign dmem_cen   = |grant;
  assign dmem_wen   = (grant[0] & req_wen[0]) | (grant[1] & req_wen[1]);
  assign dmem_strb  = ({4{grant[0]}} & req_strb[3:0]) | ({4{grant[1]}} & req_strb[7:4]);
  assign dmem_addr  = ({32{grant[0]}} & req_addr[31:0]) | ({32{grant[1]}} & req_addr[63:32]);
  assign dmem_wdata = ({32{grant[0]}} & req_wdata[31:0]) | ({32{grant[1]}} & req_wdata[63:32]);

  assign done      = dmem_cen & ~dmem_stall;
  assign req_stall = req_cen & ~(grant & {2{~dmem_stall}});
  assign req_error = grant & {2{done & dmem_error}};
  assign req_rdata = dmem_rdata;
  assign arb_owner = g_reset ? 2'b00 : (owner_q | grant);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    owner_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant[0] && dmem_stall)      state_d = LOCK0;
        else if (grant[1] && dmem_stall) state_d = LOCK1;
      end
      LOCK0:   if (!req_cen[0] || !dmem_stall) state_d = IDLE;
      LOCK1:   if (!req_cen[1] || !dmem_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The counter is frozen while port 1 itself holds the lock.
    if (state_q != LOCK1) begin
      if (!req_cen[1] || (grant[1] && done)) starve_d = '0;
      else if (starve_q < LIMIT)             starve_d = starve_q + SW'(1);
    end
    case (state_d)
      LOCK0:   owner_d = 2'b01;
      LOCK1:   owner_d = 2'b10;
      default: owner_d = 2'b00;
    endcase
  end

  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (g_reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      owner_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Self-checking bench for frv_dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural model of the arbitration rules.
module tb_frv_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [1:0]  req_cen, req_wen, req_stall, req_error, arb_owner;
  logic [7:0]  req_strb;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] req_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_cen, dmem_wen, dmem_stall, dmem_error;
  logic [3:0]  dmem_strb;

  int n_pass = 0;
  int n_total = 0;

  frv_dmem_arbiter #(.STARVE_LIMIT(LIMIT), .SW(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req_cen(req_cen), .req_wen(req_wen), .req_strb(req_strb),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_stall(req_stall), .req_error(req_error), .req_rdata(req_rdata),
    .dmem_cen(dmem_cen), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_stall(dmem_stall), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .arb_owner(arb_owner)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_cen = 2'b00; req_wen = 2'b00; req_strb = 8'h00;
    dmem_stall = 1'b0; dmem_error = 1'b0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1; req_cen = 2'b11; dmem_stall = 1'b0;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, arb_owner, req_stall} !== {1'b0, 2'b00, 2'b11})
      $display("FAIL reset_active: got cen=%b own=%b stall=%b want 0/00/11", dmem_cen, arb_owner, req_stall);
    else n_pass++;
    tick();
    g_reset = 1'b0; req_cen = 2'b00;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata, arb_owner, req_stall, req_error} !== '0)
      $display("FAIL reset_idle: got cen=%b wen=%b strb=%h addr=%h wdata=%h own=%b stall=%b err=%b want all 0",
               dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata, arb_owner, req_stall, req_error);
    else n_pass++;
    tick();
  endtask

  task automatic test_port0_read();
    req_cen = 2'b01; req_wen = 2'b00; req_addr = {32'h0, 32'h0000_1000};
    dmem_stall = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, dmem_wen, dmem_addr, req_stall, req_rdata, arb_owner} !==
        {1'b1, 1'b0, 32'h0000_1000, 2'b00, 32'hDEAD_BEEF, 2'b01})
      $display("FAIL p0_read: got cen=%b wen=%b addr=%h stall=%b rdata=%h own=%b want 1/0/00001000/00/deadbeef/01",
               dmem_cen, dmem_wen, dmem_addr, req_stall, req_rdata, arb_owner);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_own;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    for (int c = 0; c < 10; c++) begin
      req_cen = 2'b11; dmem_stall = 1'b0;
      exp_own = (c == 4 || c == 9) ? 2'b10 : 2'b01;
      @(negedge g_clk);
      n_total++;
      if ({arb_owner, dmem_addr, req_stall} !== {exp_own, (exp_own[1] ? 32'h200 : 32'h100), ~exp_own})
        $display("FAIL contention_c%0d: got own=%b addr=%h stall=%b want own=%b", c, arb_owner, dmem_addr, req_stall, exp_own);
      else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock();
    req_addr = {32'h0000_0300, 32'h0000_0400};
    for (int c = 0; c < 5; c++) begin
      req_cen    = (c == 0) ? 2'b10 : 2'b11;
      dmem_stall = (c < 3);
      @(negedge g_clk);
      n_total++;
      if (c < 4) begin
        if ({arb_owner, dmem_addr, req_stall} !== {2'b10, 32'h300, (c == 0) ? 2'b10 : (c == 3) ? 2'b01 : 2'b11})
          $display("FAIL lock_c%0d: got own=%b addr=%h stall=%b", c, arb_owner, dmem_addr, req_stall);
        else n_pass++;
      end else begin
        if ({arb_owner, dmem_addr, req_stall} !== {2'b01, 32'h400, 2'b10})
          $display("FAIL lock_after: got own=%b addr=%h stall=%b want 01/00000400/10", arb_owner, dmem_addr, req_stall);
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_error();
    req_cen = 2'b11; req_wen = 2'b11; req_strb = 8'hF3;
    req_addr = {32'h0000_0080, 32'h0000_0040}; req_wdata = {32'hAAAA_5555, 32'h1234_5678};
    dmem_stall = 1'b0; dmem_error = 1'b1;
    @(negedge g_clk);
    n_total++;
    if ({req_error, dmem_wen, dmem_strb, dmem_addr, dmem_wdata} !== {2'b01, 1'b1, 4'h3, 32'h40, 32'h1234_5678})
      $display("FAIL error_write: got err=%b wen=%b strb=%h addr=%h wdata=%h want 01/1/3/00000040/12345678",
               req_error, dmem_wen, dmem_strb, dmem_addr, dmem_wdata);
    else n_pass++;
    tick();
    idle_inputs();
    @(negedge g_clk);
    n_total++;
    if (req_error !== 2'b00) $display("FAIL error_clear: got %b want 00", req_error);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_lock();
    req_addr = {32'h0000_0900, 32'h0000_0800};
    req_cen = 2'b11; dmem_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge g_clk);
      n_total++;
      if ({arb_owner, dmem_addr} !== {2'b01, 32'h800})
        $display("FAIL rml_lock_c%0d: got own=%b addr=%h want 01/00000800", c, arb_owner, dmem_addr);
      else n_pass++;
      tick();
    end
    g_reset = 1'b1;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, arb_owner, req_stall} !== {1'b0, 2'b00, 2'b11})
      $display("FAIL rml_reset: got cen=%b own=%b stall=%b want 0/00/11", dmem_cen, arb_owner, req_stall);
    else n_pass++;
    tick();
    g_reset = 1'b0; dmem_stall = 1'b0;
    @(negedge g_clk);
    n_total++;
    if ({arb_owner, dmem_addr, req_stall} !== {2'b01, 32'h800, 2'b10})
      $display("FAIL rml_restart: got own=%b addr=%h stall=%b want 01/00000800/10", arb_owner, dmem_addr, req_stall);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    req_addr = {32'h0000_0B00, 32'h0000_0A00};
    req_cen = 2'b10; dmem_stall = 1'b1;
    tick();
    req_cen = 2'b01;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, dmem_addr, req_stall} !== {1'b0, 32'h0, 2'b01})
      $display("FAIL abort_cycle: got cen=%b addr=%h stall=%b want 0/00000000/01", dmem_cen, dmem_addr, req_stall);
    else n_pass++;
    tick();
    dmem_stall = 1'b0;
    @(negedge g_clk);
    n_total++;
    if ({dmem_cen, arb_owner, dmem_addr, req_stall} !== {1'b1, 2'b01, 32'hA00, 2'b00})
      $display("FAIL abort_next: got cen=%b own=%b addr=%h stall=%b want 1/01/00000a00/00",
               dmem_cen, arb_owner, dmem_addr, req_stall);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  // Model: lk is the port holding a lock (-1 = none), sv the starvation count.
  task automatic test_random();
    int lk, sv, g, shown;
    logic [1:0]   hold, es, ee, eo;
    logic [107:0] exp_b, got_b;
    lk = -1; sv = 0; hold = 2'b00; shown = 0;
    g_reset = 1'b1; idle_inputs();
    tick();
    g_reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (hold[i]) begin
          if ($urandom_range(15) == 0) req_cen[i] = 1'b0;
        end else begin
          req_cen[i]           = 1'($urandom_range(1));
          req_wen[i]           = 1'($urandom_range(1));
          req_strb[4*i +: 4]   = 4'($urandom);
          req_addr[32*i +: 32] = $urandom;
          req_wdata[32*i +: 32] = $urandom;
        end
      end
      dmem_stall = ($urandom_range(2) == 0);
      dmem_error = 1'($urandom_range(1));
      dmem_rdata = $urandom;
      g_reset    = ($urandom_range(40) == 0);

      if (g_reset)       g = -1;
      else if (lk >= 0)  g = req_cen[lk] ? lk : -1;
      else if (req_cen[1] && (!req_cen[0] || sv >= LIMIT)) g = 1;
      else if (req_cen[0]) g = 0;
      else               g = -1;

      for (int i = 0; i < 2; i++) begin
        es[i] = req_cen[i] && !(g == i && !dmem_stall);
        ee[i] = (g == i) && !dmem_stall && dmem_error;
      end
      eo = 2'b00;
      if (!g_reset && lk >= 0) eo[lk] = 1'b1;
      if (g >= 0) eo[g] = 1'b1;
      if (g >= 0)
        exp_b = {1'b1, req_wen[g], req_strb[4*g +: 4], req_addr[32*g +: 32], req_wdata[32*g +: 32],
                 es, ee, dmem_rdata, eo};
      else
        exp_b = {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, es, ee, dmem_rdata, eo};

      @(negedge g_clk);
      got_b = {dmem_cen, dmem_wen, dmem_strb, dmem_addr, dmem_wdata, req_stall, req_error, req_rdata, arb_owner};
      n_total++;
      if (got_b !== exp_b) begin
        if (shown < 10) $display("FAIL random_c%0d: got %h want %h", c, got_b, exp_b);
        shown++;
      end else n_pass++;

      hold = req_cen & es;
      if (g_reset) begin
        lk = -1; sv = 0;
      end else begin
        if (lk != 1) begin
          if (!req_cen[1] || (g == 1 && !dmem_stall)) sv = 0;
          else if (sv < LIMIT) sv = sv + 1;
        end
        lk = (g >= 0 && dmem_stall) ? g : -1;
      end
      tick();
    end
    g_reset = 1'b0; idle_inputs();
    tick();
  endtask

  initial begin
    g_reset = 1'b1; idle_inputs();
    req_addr = '0; req_wdata = '0; dmem_rdata = '0;
    tick();
    tick();
    test_reset();
    test_port0_read();
    test_contention();
    test_lock();
    test_error();
    test_reset_mid_lock();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
